// File: rtl/pe_bs_seq_ctrl_if.sv
// Control/stream bundle between the PE_BS frame sequencer and its environment.
// The master side drives configuration and samples; the slave side is the sequencer.
interface pe_bs_seq_ctrl_if #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned SHIFT_W = 3,
  parameter int unsigned LEN_W   = 8
);
  logic               cfg_we;
  logic [1:0]         cfg_idx;
  logic [SHIFT_W-1:0] cfg_shift;
  logic               cfg_sign;
  logic               start;
  logic [1:0]         start_sel;
  logic [LEN_W-1:0]   frame_len;
  logic               in_valid;
  logic [DATA_W-1:0]  in_data;
  logic               in_ready;
  logic [DATA_W-1:0]  pe_in;
  logic [SHIFT_W-1:0] pe_w1;
  logic [SHIFT_W-1:0] pe_w2;
  logic [SHIFT_W-1:0] pe_w3;
  logic               pe_s1;
  logic               pe_s2;
  logic               pe_s3;
  logic [1:0]         pe_sel;
  logic               pe_clr_n;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output cfg_we, cfg_idx, cfg_shift, cfg_sign, start, start_sel, frame_len,
           in_valid, in_data,
    input  in_ready, pe_in, pe_w1, pe_w2, pe_w3, pe_s1, pe_s2, pe_s3, pe_sel,
           pe_clr_n, busy, done, err
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_shift, cfg_sign, start, start_sel, frame_len,
           in_valid, in_data,
    output in_ready, pe_in, pe_w1, pe_w2, pe_w3, pe_s1, pe_s2, pe_s3, pe_sel,
           pe_clr_n, busy, done, err
  );
endinterface

// File: rtl/pe_bs_seq_ctrl.sv
// Frame sequencer for the 3-tap barrel-shift PE: holds tap weights, clears the PE,
// streams one frame of samples, flushes the PE pipeline and reports done/err.
module pe_bs_seq_ctrl #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned SHIFT_W = 3,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned FLUSH_N = 5
) (
  input logic             i_clk,
  input logic             i_rst_n,
  pe_bs_seq_ctrl_if.slave bus
);

  localparam int unsigned FlushCntW = $clog2(FLUSH_N + 1);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StStream,
    StFlush,
    StDone
  } state_e;

  state_e               r_state;
  logic [1:0]           r_sel;
  logic [LEN_W-1:0]     r_len;
  logic [LEN_W-1:0]     r_cnt;
  logic [FlushCntW-1:0] r_flush;
  logic                 r_in_ready;
  logic [DATA_W-1:0]    r_pe_in;
  logic [1:0]           r_pe_sel;
  logic                 r_pe_clr_n;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;
  logic [SHIFT_W-1:0]   r_w1, r_w2, r_w3;
  logic                 r_s1, r_s2, r_s3;

  logic                 w_accept;
  logic                 w_gap;
  logic                 w_cfg_wr;
  logic [LEN_W-1:0]     w_cnt_inc;
  logic [DATA_W-1:0]    w_pe_in_d;

  assign w_accept  = (r_state == StStream) & r_in_ready & bus.in_valid;
  // A gap only aborts once the frame has started; before that, idling is allowed.
  assign w_gap     = (r_state == StStream) & ~bus.in_valid & (r_cnt != '0);
  assign w_cfg_wr  = bus.cfg_we & ~r_busy & (bus.cfg_idx != 2'd3);
  assign w_cnt_inc = r_cnt + LEN_W'(1);
  assign w_pe_in_d = w_accept ? bus.in_data : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_w1 <= '0;
      r_w2 <= '0;
      r_w3 <= '0;
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else if (w_cfg_wr) begin
      case (bus.cfg_idx)
        2'd0: begin
          r_w1 <= bus.cfg_shift;
          r_s1 <= bus.cfg_sign;
        end
        2'd1: begin
          r_w2 <= bus.cfg_shift;
          r_s2 <= bus.cfg_sign;
        end
        2'd2: begin
          r_w3 <= bus.cfg_shift;
          r_s3 <= bus.cfg_sign;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_sel      <= 2'd3;
      r_len      <= '0;
      r_cnt      <= '0;
      r_flush    <= '0;
      r_in_ready <= 1'b0;
      r_pe_in    <= '0;
      r_pe_sel   <= 2'd3;
      r_pe_clr_n <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_pe_clr_n <= 1'b1;
      r_pe_in    <= w_pe_in_d;
      case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_sel      <= bus.start_sel;
            r_len      <= bus.frame_len;
            r_pe_clr_n <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= StClear;
          end
        end
        StClear: begin
          r_cnt    <= '0;
          r_pe_sel <= r_sel;
          if (r_len == '0) begin
            r_flush <= FlushCntW'(FLUSH_N - 1);
            r_state <= StFlush;
          end else begin
            r_in_ready <= 1'b1;
            r_state    <= StStream;
          end
        end
        StStream: begin
          if (w_accept) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == r_len) begin
              r_in_ready <= 1'b0;
              r_flush    <= FlushCntW'(FLUSH_N - 1);
              r_state    <= StFlush;
            end
          end else if (w_gap) begin
            r_in_ready <= 1'b0;
            r_pe_sel   <= 2'd3;
            r_busy     <= 1'b0;
            r_err      <= 1'b1;
            r_state    <= StIdle;
          end
        end
        StFlush: begin
          if (r_flush == '0) begin
            // Freeze the accumulators so y1..y3 hold until the next clear.
            r_pe_sel <= 2'd3;
            r_done   <= 1'b1;
            r_state  <= StDone;
          end else begin
            r_flush <= r_flush - FlushCntW'(1);
          end
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_in_ready <= 1'b0;
          r_pe_sel   <= 2'd3;
          r_busy     <= 1'b0;
          r_state    <= StIdle;
        end
      endcase
    end
  end

  assign bus.in_ready = r_in_ready;
  assign bus.pe_in    = r_pe_in;
  assign bus.pe_w1    = r_w1;
  assign bus.pe_w2    = r_w2;
  assign bus.pe_w3    = r_w3;
  assign bus.pe_s1    = r_s1;
  assign bus.pe_s2    = r_s2;
  assign bus.pe_s3    = r_s3;
  assign bus.pe_sel   = r_pe_sel;
  assign bus.pe_clr_n = r_pe_clr_n;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.err      = r_err;

endmodule

// File: tb/tb_pe_bs_seq_ctrl.sv
// Randomized bench for pe_bs_seq_ctrl: each frame is scored against a transaction-level
// model (sample sums delivered to the PE, done latency, error pulses, weight table).
module tb_pe_bs_seq_ctrl;

  logic clk;
  logic rst_n;

  pe_bs_seq_ctrl_if #(.DATA_W(8), .SHIFT_W(3), .LEN_W(8)) bus ();

  pe_bs_seq_ctrl #(.DATA_W(8), .SHIFT_W(3), .LEN_W(8), .FLUSH_N(5)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference weight table
  logic [2:0] m_w [3];
  logic       m_s [3];
  logic [2:0] obs_w [3];
  logic       obs_s [3];

  always_comb begin
    obs_w[0] = bus.pe_w1;
    obs_w[1] = bus.pe_w2;
    obs_w[2] = bus.pe_w3;
    obs_s[0] = bus.pe_s1;
    obs_s[1] = bus.pe_s2;
    obs_s[2] = bus.pe_s3;
  end

  task automatic idle_inputs();
    bus.cfg_we    = 1'b0;
    bus.cfg_idx   = 2'd0;
    bus.cfg_shift = 3'd0;
    bus.cfg_sign  = 1'b0;
    bus.start     = 1'b0;
    bus.start_sel = 2'd0;
    bus.frame_len = 8'd0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'd0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++) begin
      m_w[i] = 3'd0;
      m_s[i] = 1'b0;
    end
  endtask

  // Drive one configuration write at the current negedge; model follows the rules.
  task automatic cfg_write(input int idx, input int shift, input bit sign);
    bus.cfg_we    = 1'b1;
    bus.cfg_idx   = 2'(idx);
    bus.cfg_shift = 3'(shift);
    bus.cfg_sign  = sign;
    if (idx < 3 && bus.busy === 1'b0) begin
      m_w[idx] = 3'(shift);
      m_s[idx] = sign;
    end
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    clear_model();
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
    n_cmp++; if (bus.pe_in !== 8'd0) begin n_bad++; $display("FAIL reset_pe_in got %0d want 0", bus.pe_in); end
    n_cmp++; if (bus.pe_sel !== 2'd3) begin n_bad++; $display("FAIL reset_pe_sel got %0d want 3", bus.pe_sel); end
    n_cmp++; if (bus.pe_clr_n !== 1'b1) begin n_bad++; $display("FAIL reset_pe_clr_n got %b want 1", bus.pe_clr_n); end
    n_cmp++; if ({bus.busy, bus.done, bus.err} !== 3'b000) begin n_bad++; $display("FAIL reset_status got %b want 000", {bus.busy, bus.done, bus.err}); end
    n_cmp++; if ({bus.pe_w1, bus.pe_w2, bus.pe_w3, bus.pe_s1, bus.pe_s2, bus.pe_s3} !== 12'd0) begin
      n_bad++; $display("FAIL reset_weights got %h want 0", {bus.pe_w1, bus.pe_w2, bus.pe_w3, bus.pe_s1, bus.pe_s2, bus.pe_s3});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_weights();
    for (int k = 0; k < 12; k++) begin
      cfg_write($urandom_range(0, 3), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (obs_w[i] !== m_w[i] || obs_s[i] !== m_s[i]) begin
          n_bad++;
          $display("FAIL weight_write tap%0d got w=%0d s=%b want w=%0d s=%b", i, obs_w[i], obs_s[i], m_w[i], m_s[i]);
        end
      end
    end
  endtask

  // Run one frame. gap_at>0 drops in_valid after that many accepts (abort expected if < len).
  task automatic run_frame(input int sel, input int len, input int idle_pre, input int gap_at,
                           input bit busy_noise, input bit start_cfg);
    int  acc = 0, cyc = 0, idle = idle_pre, t_ref = -1, t_done = -1;
    int  n_clr = 0, n_done = 0, n_errp = 0, rdy_flush = 0, cfg_tap = 0;
    int  sum_exp = 0, sum_obs = 0;
    bit  prev_acc = 1'b0, end_pending = 1'b0, finished = 1'b0, stopped = 1'b0;
    bit  expect_err;
    logic [7:0] prev_d = 8'd0;
    expect_err = (gap_at > 0) && (gap_at < len);

    bus.start     = 1'b1;
    bus.start_sel = 2'(sel);
    bus.frame_len = 8'(len);
    if (start_cfg) begin
      cfg_tap       = $urandom_range(0, 2);
      bus.cfg_we    = 1'b1;
      bus.cfg_idx   = 2'(cfg_tap);
      bus.cfg_shift = 3'($urandom_range(0, 7));
      bus.cfg_sign  = 1'($urandom_range(0, 1));
      m_w[cfg_tap]  = bus.cfg_shift;
      m_s[cfg_tap]  = bus.cfg_sign;
    end
    @(negedge clk);
    bus.start  = 1'b0;
    bus.cfg_we = 1'b0;
    n_cmp++; if (bus.pe_clr_n !== 1'b0 || bus.busy !== 1'b1) begin
      n_bad++; $display("FAIL clear_cycle got clr_n=%b busy=%b want 0 1", bus.pe_clr_n, bus.busy);
    end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL clear_in_ready got %b want 0", bus.in_ready); end
    if (start_cfg) begin
      n_cmp++; if (obs_w[cfg_tap] !== m_w[cfg_tap] || obs_s[cfg_tap] !== m_s[cfg_tap]) begin
        n_bad++; $display("FAIL start_with_cfg tap%0d got w=%0d want w=%0d", cfg_tap, obs_w[cfg_tap], m_w[cfg_tap]);
      end
    end
    if (len == 0) t_ref = 0;

    while (!finished && cyc < 700) begin
      @(negedge clk);
      cyc++;
      n_cmp++;
      if (bus.pe_in !== (prev_acc ? prev_d : 8'd0)) begin
        n_bad++; $display("FAIL pe_in cyc%0d got %0d want %0d", cyc, bus.pe_in, prev_acc ? prev_d : 8'd0);
      end
      if (bus.pe_sel !== 2'd3) sum_obs += int'(bus.pe_in);
      if (bus.pe_clr_n !== 1'b1) n_clr++;
      if (t_ref >= 0 && t_done < 0 && bus.in_ready === 1'b1) rdy_flush++;
      if (end_pending) begin
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL busy_after_end got %b want 0", bus.busy); end
        finished = 1'b1;
      end
      if (bus.err === 1'b1) begin
        n_errp++;
        stopped = 1'b1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL busy_on_err got %b want 0", bus.busy); end
        end_pending = 1'b1;
      end
      if (bus.done === 1'b1) begin
        n_done++;
        t_done = cyc;
        stopped = 1'b1;
        end_pending = 1'b1;
      end

      prev_acc   = 1'b0;
      bus.cfg_we = 1'b0;
      bus.start  = 1'b0;
      if (busy_noise && bus.busy === 1'b1) begin
        bus.cfg_we    = 1'b1;
        bus.cfg_idx   = 2'($urandom_range(0, 3));
        bus.cfg_shift = 3'($urandom_range(0, 7));
        bus.cfg_sign  = 1'($urandom_range(0, 1));
        bus.start     = 1'b1;
        bus.start_sel = 2'($urandom_range(0, 3));
        bus.frame_len = 8'($urandom_range(0, 9));
      end
      bus.in_valid = 1'b0;
      if (acc < len && !stopped) begin
        if (idle > 0) idle--;
        else if (gap_at > 0 && acc == gap_at) bus.in_valid = 1'b0;
        else begin
          bus.in_valid = 1'b1;
          bus.in_data  = 8'($urandom_range(0, 255));
        end
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
        prev_acc = 1'b1;
        prev_d   = bus.in_data;
        acc++;
        if (sel != 3) sum_exp += int'(bus.in_data);
        if (acc == len) t_ref = cyc;
      end
    end
    idle_inputs();

    n_cmp++; if (!finished) begin n_bad++; $display("FAIL frame_timeout got cyc=%0d want end of frame", cyc); end
    n_cmp++; if (n_clr != 0) begin n_bad++; $display("FAIL extra_clear got %0d want 0", n_clr); end
    n_cmp++; if (sum_obs != sum_exp) begin n_bad++; $display("FAIL pe_sum sel%0d got %0d want %0d", sel, sum_obs, sum_exp); end
    if (expect_err) begin
      n_cmp++; if (n_errp != 1 || n_done != 0) begin
        n_bad++; $display("FAIL abort_pulses got err=%0d done=%0d want 1 0", n_errp, n_done);
      end
      n_cmp++; if (acc != gap_at) begin n_bad++; $display("FAIL abort_accepts got %0d want %0d", acc, gap_at); end
    end else begin
      n_cmp++; if (n_errp != 0 || n_done != 1) begin
        n_bad++; $display("FAIL frame_pulses got err=%0d done=%0d want 0 1", n_errp, n_done);
      end
      n_cmp++; if (t_done - t_ref != 6) begin
        n_bad++; $display("FAIL done_latency got %0d want 6", t_done - t_ref);
      end
      n_cmp++; if (rdy_flush != 0) begin n_bad++; $display("FAIL ready_in_flush got %0d want 0", rdy_flush); end
      n_cmp++; if (acc != len) begin n_bad++; $display("FAIL frame_accepts got %0d want %0d", acc, len); end
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (obs_w[i] !== m_w[i] || obs_s[i] !== m_s[i]) begin
        n_bad++; $display("FAIL weights_after_frame tap%0d got w=%0d want w=%0d", i, obs_w[i], m_w[i]);
      end
    end
  endtask

  task automatic test_basic();
    cfg_write(0, 1, 1'b1);
    run_frame(0, 4, 0, 0, 1'b0, 1'b0);
    cfg_write(1, 2, 1'b0);
    run_frame(1, 2, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_idle_first();
    run_frame(0, 4, 3, 0, 1'b0, 1'b0);
  endtask

  task automatic test_gap_abort();
    run_frame(1, 4, 0, 2, 1'b0, 1'b0);
    n_cmp++; if (bus.pe_sel !== 2'd3) begin n_bad++; $display("FAIL abort_pe_sel got %0d want 3", bus.pe_sel); end
  endtask

  task automatic test_zero_len();
    run_frame(2, 0, 0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_sel3_and_start_cfg();
    run_frame(3, 5, 1, 0, 1'b0, 1'b1);
    run_frame(2, 3, 0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      int len, gap;
      len = $urandom_range(1, 24);
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len) : 0;
      run_frame($urandom_range(0, 3), len, $urandom_range(0, 3), gap,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid();
    cfg_write(2, 5, 1'b1);
    bus.start     = 1'b1;
    bus.start_sel = 2'd0;
    bus.frame_len = 8'd10;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd77;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    clear_model();
    n_cmp++; if (bus.in_ready !== 1'b0 || bus.pe_in !== 8'd0) begin
      n_bad++; $display("FAIL midreset_stream got rdy=%b pe_in=%0d want 0 0", bus.in_ready, bus.pe_in);
    end
    n_cmp++; if (bus.pe_sel !== 2'd3 || bus.pe_clr_n !== 1'b1) begin
      n_bad++; $display("FAIL midreset_pe got sel=%0d clr_n=%b want 3 1", bus.pe_sel, bus.pe_clr_n);
    end
    n_cmp++; if ({bus.busy, bus.done, bus.err} !== 3'b000 || bus.pe_w3 !== 3'd0 || bus.pe_s3 !== 1'b0) begin
      n_bad++; $display("FAIL midreset_status got %b w3=%0d want 000 0", {bus.busy, bus.done, bus.err}, bus.pe_w3);
    end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_bad++; $display("FAIL after_reset_idle got busy=%b rdy=%b want 0 0", bus.busy, bus.in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_weights();
    test_basic();
    test_idle_first();
    test_gap_abort();
    test_zero_len();
    test_sel3_and_start_cfg();
    test_back_to_back();
    test_reset_mid();
    run_frame(0, 3, 0, 0, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
